crc_frame_arbiter: RTL and testbench
====================================

Name: crc_frame_arbiter

Overview:
- Shares one byte-serial CRC-16 engine (poly 0x1021, MSB-first) between two byte-stream requesters, e.g. the UART TX framer and the UART RX checker.
- Grants the engine for a whole frame at a time, round-robin between requesters.
- Accumulates the CRC over the frame and presents the result with the requester id and frame length on a held-until-accepted result port.
- Sits between the UART byte paths and the frame append/compare logic.

Parameters:
- POLY, 16'h1021, CRC generator polynomial.
- INIT, 16'h0000, CRC register value loaded at frame start.
- MAX_LEN, 256, maximum bytes per frame before forced termination (1..2^LEN_W-1).
- LEN_W, 9, width of byte counter / res_len.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 byte valid
- req0_data  in  8  requester 0 byte
- req0_last  in  1  requester 0 final byte of frame
- req0_ready  out  1  requester 0 byte accepted when valid&ready
- req1_valid  in  1  requester 1 byte valid
- req1_data  in  8  requester 1 byte
- req1_last  in  1  requester 1 final byte of frame
- req1_ready  out  1  requester 1 byte accepted when valid&ready
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_crc  out  16  final CRC of frame
- res_id  out  1  requester that owned the frame
- res_len  out  LEN_W  bytes in frame
- res_err  out  1  frame terminated by MAX_LEN, not by last
- busy  out  1  state != IDLE

Behaviour:
- Reset is asynchronous, active-high; clock is clk. On reset: state=IDLE, crc=INIT, count=0, rr_pri=0 (requester 0 preferred), all outputs 0.
- Reset mid-frame or mid-result discards everything; no result is emitted.
- CRC byte update, computed combinationally, registered on accept:
  - t = crc ^ {8'h00, data}.
  - Repeat 8 times: if t[15] then t = (t<<1) ^ POLY, else t = t<<1.
  - crc <= t.
- States: IDLE, RUN, RESULT.
- IDLE:
  - No ready asserted.
  - If any reqN_valid: grant = rr_pri if req[rr_pri]_valid, else the other. Latch grant into id; crc <= INIT; count <= 0; go to RUN.
  - Arbitration costs exactly 1 cycle: first byte can be accepted the cycle after the request is seen.
- RUN:
  - req[id]_ready = 1; the other ready = 0.
  - Each accept (valid&ready) updates crc and increments count.
  - valid low stalls with grant held; there is no timeout.
  - On an accept with last=1: go to RESULT, res_err=0.
  - On an accept with last=0 that makes count == MAX_LEN: go to RESULT, res_err=1. The requester's following bytes form its next frame.
  - A MAX_LEN-th byte with last=1 is a normal frame (res_err=0).
- RESULT:
  - res_valid=1.
  - res_crc/res_id/res_len/res_err reflect the post-final-byte values and are stable while res_valid && !res_ready.
  - Both readys = 0.
  - On res_valid&res_ready: rr_pri <= ~id, res_valid <= 0, state <= IDLE.
- Result-port details:
  - Earliest next grant is the cycle after the result is accepted: 2-cycle bubble between back-to-back frames.
  - res_* fields hold their last values after acceptance; only res_valid qualifies them.
- Simultaneous requests: resolved by rr_pri only. A requester that is continuously valid is never starved: at most one other frame is served before it.
- All outputs are registered except reqN_ready, which are decoded from state and id only, never from reqN_valid.
- Arithmetic: count is LEN_W bits and cannot wrap, since it is capped by MAX_LEN.

Test Plan:
- Basic frame: after reset, req0 sends bytes 0x01 then 0x00 (last on 2nd), res_ready=1 → res_valid pulse with res_crc=0x1021, res_id=0, res_len=2, res_err=0. Single byte 0x01 with last gives res_crc=0x0100, len=1.
- Simultaneous start: req0 and req1 both valid in the same cycle after reset, each sending 1-byte frame 0x00 → req0 served first (crc 0x0000, id 0), then req1 (id 1). Repeat the pair → order is again req0 then req1, per rr_pri after req1's acceptance.
- Backpressure and stall:
  - req1 frame {0x01,0x00} with a 3-cycle valid gap between bytes → req1_ready stays high and req0_ready stays 0 throughout.
  - Hold res_ready=0 for 5 cycles → res_* stable, no new grant issued, result 0x1021/id1 accepted on the first res_ready.
- Overlength with MAX_LEN=4: req0 sends 6 bytes 0x00 with last only on the 6th → first result len=4, err=1. The second frame is granted afterwards: len=2, err=0, with req1 idle.
- Reset mid-frame: assert reset after 1 of 2 bytes → readys and res_valid drop immediately. A new frame {0x01,0x00} afterwards gives 0x1021, proving crc was reset to INIT.
- Random regression: random valid/last/res_ready on both requesters against a reference model → CRC, ownership and length match for every frame; no byte is accepted from the non-granted requester.

Source files
------------

// File: rtl/crc_frame_arbiter.sv
// rtl/crc_frame_arbiter.sv - frame-granular round-robin sharing of one byte-serial CRC-16 engine
module crc_frame_arbiter #(
    parameter logic [15:0] POLY    = 16'h1021,
    parameter logic [15:0] INIT    = 16'h0000,
    parameter int          MAX_LEN = 256,
    parameter int          LEN_W   = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_crc,
    output logic             res_id,
    output logic [LEN_W-1:0] res_len,
    output logic             res_err,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, RESULT} state_t;

    state_t           state, state_nxt;
    logic             id;
    logic             rr_pri;
    logic [15:0]      crc;
    logic [LEN_W-1:0] count;

    logic             cur_valid, cur_last, accept, at_max, frame_end, grant_sel;
    logic [7:0]       cur_data;
    logic [LEN_W-1:0] count_inc;
    logic [15:0]      crc_nxt;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] t;
        t = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            t = t[15] ? ((t << 1) ^ POLY) : (t << 1);
        end
        return t;
    endfunction

    assign cur_valid = id ? req1_valid : req0_valid;
    assign cur_data  = id ? req1_data  : req0_data;
    assign cur_last  = id ? req1_last  : req0_last;
    assign accept    = (state == RUN) && cur_valid;
    assign count_inc = count + 1'b1;
    assign at_max    = (count_inc == LEN_W'(MAX_LEN));
    assign frame_end = accept && (cur_last || at_max);
    assign crc_nxt   = crc_byte(crc, cur_data);
    // Preferred requester wins when it is asking; otherwise the other one must be.
    assign grant_sel = (rr_pri ? req1_valid : req0_valid) ? rr_pri : ~rr_pri;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0_valid || req1_valid) state_nxt = RUN;
            RUN:     if (frame_end)                state_nxt = RESULT;
            RESULT:  if (res_ready)                state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    // Readys depend on state and owner only, never on the requesters' valids.
    always_comb begin
        req0_ready = (state == RUN) && !id;
        req1_ready = (state == RUN) &&  id;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id        <= 1'b0;
            rr_pri    <= 1'b0;
            crc       <= INIT;
            count     <= '0;
            res_valid <= 1'b0;
            res_crc   <= 16'h0000;
            res_id    <= 1'b0;
            res_len   <= '0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        id    <= grant_sel;
                        crc   <= INIT;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        crc   <= crc_nxt;
                        count <= count_inc;
                    end
                    if (frame_end) begin
                        res_crc <= crc_nxt;
                        res_id  <= id;
                        res_len <= count_inc;
                        res_err <= !cur_last;
                    end
                end
                RESULT: begin
                    if (res_ready) rr_pri <= ~id;
                end
                default: ;
            endcase
            res_valid <= (state_nxt == RESULT);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_crc_frame_arbiter.sv
// tb/tb_crc_frame_arbiter.sv - directed table, corner sequences and random model check of crc_frame_arbiter
module tb_crc_frame_arbiter;

    localparam int MAX_LEN = 4;
    localparam int LEN_W   = 9;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       vld, lst;
    logic [7:0]       dat [2];
    logic             res_ready;
    logic             ready0, ready1, res_valid, res_id, res_err, busy;
    logic [15:0]      res_crc;
    logic [LEN_W-1:0] res_len;

    crc_frame_arbiter #(.POLY(16'h1021), .INIT(16'h0000), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(vld[0]), .req0_data(dat[0]), .req0_last(lst[0]), .req0_ready(ready0),
        .req1_valid(vld[1]), .req1_data(dat[1]), .req1_last(lst[1]), .req1_ready(ready1),
        .res_valid(res_valid), .res_ready(res_ready), .res_crc(res_crc), .res_id(res_id),
        .res_len(res_len), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        rid;
        logic [2:0]  n;
        logic [31:0] bytes;
        logic [15:0] crc;
        logic [8:0]  len;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [15:0] crc;
        logic        id;
        logic [8:0]  len;
        logic        err;
    } res_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_of(input logic r);
        return r ? ready1 : ready0;
    endfunction

    // Reference: (crc ^ data) * x^8 mod P by polynomial long division.
    function automatic logic [15:0] ref_crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [23:0] v;
        v = {c ^ {8'h00, d}, 8'h00};
        for (int b = 23; b >= 16; b--) begin
            if (v[b]) v = v ^ (24'h011021 << (b - 16));
        end
        return v[15:0];
    endfunction

    task automatic do_reset;
        reset = 1'b1; vld = 2'b00; lst = 2'b00; dat[0] = 8'h00; dat[1] = 8'h00; res_ready = 1'b1;
        tick; tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic send_byte(input logic rid, input logic [7:0] d, input logic last);
        bit done;
        done = 0;
        vld[rid] = 1'b1; dat[rid] = d; lst[rid] = last;
        for (int c = 0; c < 20 && !done; c++) begin
            if (ready_of(rid)) done = 1;
            tick;
        end
        vld[rid] = 1'b0;
        if (!done) timeout_fail("send_byte");
    endtask

    task automatic send_frame(input logic rid, input int n, input logic [31:0] bytes, input bit use_last);
        for (int i = 0; i < n; i++) send_byte(rid, bytes[8*i +: 8], use_last && (i == n - 1));
    endtask

    task automatic expect_result(input string nm, input logic [15:0] crc, input logic id,
                                 input logic [8:0] len, input logic err);
        bit seen;
        seen = 0;
        res_ready = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (res_valid) seen = 1;
            else tick;
        end
        if (!seen) timeout_fail(nm);
        else begin
            check({nm, "_crc"}, 32'(res_crc), 32'(crc));
            check({nm, "_id"},  32'(res_id),  32'(id));
            check({nm, "_len"}, 32'(res_len), 32'(len));
            check({nm, "_err"}, 32'(res_err), 32'(err));
            tick;
        end
    endtask

    task automatic run_pair(input string nm);
        logic ids [2];
        int   got;
        logic a0, a1, r, rid;
        got = 0;
        vld = 2'b11; lst = 2'b11; dat[0] = 8'h00; dat[1] = 8'h00; res_ready = 1'b1;
        tick;
        check({nm, "_arb_ready0"}, 32'(ready0), 32'd1);
        check({nm, "_arb_ready1"}, 32'(ready1), 32'd0);
        for (int c = 0; c < 30 && got < 2; c++) begin
            a0 = vld[0] & ready0; a1 = vld[1] & ready1;
            r = res_valid & res_ready; rid = res_id;
            tick;
            if (a0) vld[0] = 1'b0;
            if (a1) vld[1] = 1'b0;
            if (r) begin ids[got] = rid; got++; end
        end
        vld = 2'b00;
        if (got < 2) timeout_fail(nm);
        else begin
            check({nm, "_first"},  32'(ids[0]), 32'd0);
            check({nm, "_second"}, 32'(ids[1]), 32'd1);
        end
    endtask

    // Random-regression model state
    logic        pri_m, grant_m;
    logic [15:0] fcrc;
    int          flen, nres;
    res_t        expq [$];

    task automatic rnd_cycle(input bit active);
        res_t e;
        if (active) begin
            for (int i = 0; i < 2; i++) begin
                vld[i] = ($urandom_range(0, 9) < 7);
                dat[i] = 8'($urandom);
                lst[i] = ($urandom_range(0, 3) == 0);
            end
            res_ready = ($urandom_range(0, 2) != 0);
        end else begin
            vld = 2'b00; res_ready = 1'b1;
        end
        if (ready0 && ready1) check("rnd_excl_ready", 32'd1, 32'd0);
        if (!busy && vld != 2'b00) grant_m = vld[pri_m] ? pri_m : ~pri_m;
        for (int i = 0; i < 2; i++) begin
            if (vld[i] && ready_of(i[0])) begin
                check("rnd_owner", 32'(i), 32'(grant_m));
                fcrc = ref_crc_byte(fcrc, dat[i]);
                flen++;
                if (lst[i] || flen == MAX_LEN) begin
                    expq.push_back('{crc: fcrc, id: grant_m, len: 9'(flen), err: !lst[i]});
                    fcrc = 16'h0000;
                    flen = 0;
                end
            end
        end
        if (res_valid && res_ready) begin
            if (expq.size() == 0) check("rnd_unexpected_result", 32'd1, 32'd0);
            else begin
                e = expq.pop_front();
                check("rnd_crc", 32'(res_crc), 32'(e.crc));
                check("rnd_id",  32'(res_id),  32'(e.id));
                check("rnd_len", 32'(res_len), 32'(e.len));
                check("rnd_err", 32'(res_err), 32'(e.err));
                pri_m = ~e.id;
                nres++;
            end
        end
        tick;
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{rid: 1'b0, n: 3'd2, bytes: 32'h0000_0001, crc: 16'h1021, len: 9'd2, err: 1'b0};
        vecs[1] = '{rid: 1'b0, n: 3'd1, bytes: 32'h0000_0001, crc: 16'h0100, len: 9'd1, err: 1'b0};
        vecs[2] = '{rid: 1'b1, n: 3'd1, bytes: 32'h0000_0000, crc: 16'h0000, len: 9'd1, err: 1'b0};
        vecs[3] = '{rid: 1'b1, n: 3'd2, bytes: 32'h0000_0001, crc: 16'h1021, len: 9'd2, err: 1'b0};
        vecs[4] = '{rid: 1'b0, n: 3'd1, bytes: 32'h0000_00FF, crc: 16'hFF00, len: 9'd1, err: 1'b0};
        vecs[5] = '{rid: 1'b1, n: 3'd4, bytes: 32'h0000_0001, crc: 16'h3730, len: 9'd4, err: 1'b0};

        reset = 1'b1; vld = 2'b00; lst = 2'b00; dat[0] = 8'h00; dat[1] = 8'h00; res_ready = 1'b0;
        tick; tick;
        check("rst_ready0",    32'(ready0),    32'd0);
        check("rst_ready1",    32'(ready1),    32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_res_crc",   32'(res_crc),   32'd0);
        reset = 1'b0;
        tick;

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].rid, int'(vecs[v].n), vecs[v].bytes, 1'b1);
            expect_result($sformatf("vec%0d", v), vecs[v].crc, vecs[v].rid, vecs[v].len, vecs[v].err);
        end

        do_reset;
        run_pair("pair1");
        run_pair("pair2");

        // Stalled request with a valid gap, then a held result
        res_ready = 1'b0;
        send_byte(1'b1, 8'h01, 1'b0);
        vld[0] = 1'b1; dat[0] = 8'h55; lst[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("gap_ready1", 32'(ready1), 32'd1);
            check("gap_ready0", 32'(ready0), 32'd0);
            tick;
        end
        send_byte(1'b1, 8'h00, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check("hold_valid",  32'(res_valid),      32'd1);
            check("hold_crc",    32'(res_crc),        32'h1021);
            check("hold_id",     32'(res_id),         32'd1);
            check("hold_len",    32'(res_len),        32'd2);
            check("hold_noready", 32'({ready0, ready1}), 32'd0);
            tick;
        end
        res_ready = 1'b1;
        tick;
        vld[0] = 1'b0;
        check("hold_accepted", 32'(res_valid), 32'd0);
        check("hold_fields_kept", 32'(res_crc), 32'h1021);
        tick;

        // Overlength split at MAX_LEN
        send_frame(1'b0, 4, 32'h0000_0000, 1'b0);
        expect_result("ovl1", 16'h0000, 1'b0, 9'd4, 1'b1);
        send_frame(1'b0, 2, 32'h0000_0000, 1'b1);
        expect_result("ovl2", 16'h0000, 1'b0, 9'd2, 1'b0);

        // Reset in the middle of a frame
        send_byte(1'b0, 8'h01, 1'b0);
        vld[0] = 1'b1; dat[0] = 8'h00; lst[0] = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_ready0", 32'(ready0),    32'd0);
        check("mid_rst_valid",  32'(res_valid), 32'd0);
        check("mid_rst_busy",   32'(busy),      32'd0);
        vld = 2'b00;
        tick;
        reset = 1'b0;
        tick;
        send_frame(1'b0, 2, 32'h0000_0001, 1'b1);
        expect_result("post_rst", 16'h1021, 1'b0, 9'd2, 1'b0);

        // Random regression against the frame-level model
        do_reset;
        pri_m = 1'b0; grant_m = 1'b0; fcrc = 16'h0000; flen = 0; nres = 0;
        for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
        for (int c = 0; c < 20; c++) rnd_cycle(1'b0);
        check("rnd_drained", 32'(expq.size()), 32'd0);
        check("rnd_enough_frames", 32'(nres > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
